// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 74S151 scan sequencer.
// State encodings, bus widths and mode values.
package mux_scan_pkg;

  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  localparam logic MODE_SCAN   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/mux_scan_timer.sv
// Settle down-counter: load sets the count, en decrements it.
// Ports: clk, reset, load, load_val[1:0], en, tc (count is zero).
module mux_scan_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       en,
  output logic       tc
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != 2'd0)) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 2'd0;
    else       cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == 2'd0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Drives a 74S151 select/enable and samples Q/Q_N into a byte.
// Ports: clk, reset, start/mode/sel_in, sel/ce_n, q_in/q_n_in, busy/valid/data/err.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_in,
  output logic [SEL_W-1:0]  sel,
  output logic              ce_n,
  input  logic              q_in,
  input  logic              q_n_in,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  localparam int SC = (SETTLE_CYCLES < 1) ? 1 :
                      (SETTLE_CYCLES > 4) ? 4 : SETTLE_CYCLES;
  // Timer reaches zero after SC-1 decrements, so SETTLE lasts SC cycles.
  localparam logic [1:0] LOAD_VAL = 2'(SC - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               mode_q, mode_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_q, err_d;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_tc;

  mux_scan_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (LOAD_VAL),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    data_d   = data_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          mode_d   = mode;
          idx_d    = (mode == MODE_SINGLE) ? sel_in : '0;
          data_d   = '0;
          err_d    = 1'b0;
          tmr_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_tc) state_d = ST_SAMPLE;
        else        tmr_en  = 1'b1;
      end
      ST_SAMPLE: begin
        data_d[idx_q] = q_in;
        // Q and Q_N agreeing means the mux output is not trustworthy.
        if (q_in == q_n_in) err_d = 1'b1;
        if ((mode_q == MODE_SCAN) && (idx_q != 3'd7)) begin
          idx_d    = idx_q + 3'd1;
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mode_q  <= MODE_SCAN;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Select holds through DONE; it only moves when SETTLE is entered.
  assign sel   = (state_q == ST_IDLE) ? '0 : idx_q;
  assign ce_n  = !((state_q == ST_SETTLE) || (state_q == ST_SAMPLE));
  assign busy  = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign valid = (state_q == ST_DONE);
  assign data  = data_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a 74S151 behavioural model.
// Covers scan, single read, error flag, ignored starts, reset and settle=3.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start3, mode;
  logic [2:0] sel_in;
  logic [7:0] mux_in;
  logic       force_on;
  logic [2:0] force_sel;

  logic [2:0] sel0, sel3;
  logic       ce_n0, ce_n3, q0, qn0, q3, qn3;
  logic       busy0, busy3, valid0, valid3, err0, err3;
  logic [7:0] data0, data3;

  // 74S151: Y = I[sel] when enabled, else 0; W is its complement.
  assign q0  = ce_n0 ? 1'b0 : mux_in[sel0];
  assign qn0 = (force_on && !ce_n0 && sel0 == force_sel) ? q0 : ~q0;
  assign q3  = ce_n3 ? 1'b0 : mux_in[sel3];
  assign qn3 = ~q3;

  mux_scan_sequencer u0 (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .sel_in(sel_in), .sel(sel0), .ce_n(ce_n0), .q_in(q0),
    .q_n_in(qn0), .busy(busy0), .valid(valid0), .data(data0),
    .err(err0)
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .mode(mode),
    .sel_in(sel_in), .sel(sel3), .ce_n(ce_n3), .q_in(q3),
    .q_n_in(qn3), .busy(busy3), .valid(valid3), .data(data3),
    .err(err3)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       md;
    logic [2:0] si;
    logic [7:0] pat;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[7];

  // Starts an operation at the current negedge and follows it to valid.
  task automatic run_op(input bit which, input logic md,
                        input logic [2:0] si, input logic [7:0] exp_d,
                        input logic exp_e, input int mid_start,
                        input bit done_start, input string nm);
    int s, lat, bad, exp_lat;
    logic [2:0] es, sl;
    logic v, b, c;
    s = which ? 3 : 1;
    exp_lat = md ? s + 2 : 8 * (s + 1) + 1;
    mode = md;
    sel_in = si;
    if (which) start3 = 1'b1;
    else       start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start3 = 1'b0;
    lat = 1;
    bad = 0;
    while (lat < 80) begin
      v  = which ? valid3 : valid0;
      b  = which ? busy3  : busy0;
      c  = which ? ce_n3  : ce_n0;
      sl = which ? sel3   : sel0;
      if (v) break;
      es = md ? si : 3'((lat - 1) / (s + 1));
      if (!b || c || sl !== es) bad++;
      if (lat == mid_start) begin
        if (which) start3 = 1'b1;
        else       start  = 1'b1;
        mode = ~md;
        sel_in = ~si;
      end else begin
        start = 1'b0;
        start3 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    start3 = 1'b0;
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " seq"}, bad, 0);
    chk({nm, " data"}, which ? data3 : data0, exp_d);
    chk({nm, " err"}, which ? err3 : err0, exp_e);
    chk({nm, " busy@valid"}, which ? busy3 : busy0, 0);
    chk({nm, " ce_n@valid"}, which ? ce_n3 : ce_n0, 1);
    if (done_start) begin
      if (which) start3 = 1'b1;
      else       start  = 1'b1;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    start3 = 1'b0;
    mode = 1'b0;
    sel_in = 3'd0;
    mux_in = 8'h00;
    force_on = 1'b0;
    force_sel = 3'd0;

    vecs[0] = '{1'b0, 3'd0, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 3'd5, 8'h20, 8'h20};
    vecs[2] = '{1'b0, 3'd0, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 3'd0, 8'hFF, 8'hFF};
    vecs[4] = '{1'b1, 3'd0, 8'hFE, 8'h00};
    vecs[5] = '{1'b1, 3'd7, 8'h80, 8'h80};
    vecs[6] = '{1'b1, 3'd2, 8'hFF, 8'h04};

    repeat (3) @(negedge clk);
    chk("rst sel", sel0, 0);
    chk("rst ce_n", ce_n0, 1);
    chk("rst busy", busy0, 0);
    chk("rst valid", valid0, 0);
    chk("rst data", data0, 8'h00);
    chk("rst err", err0, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      mux_in = vecs[i].pat;
      run_op(1'b0, vecs[i].md, vecs[i].si, vecs[i].exp_d, 1'b0,
             0, 1'b0, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Error injected on the sel=3 sample only.
    mux_in = 8'h5A;
    force_on = 1'b1;
    force_sel = 3'd3;
    run_op(1'b0, 1'b0, 3'd0, 8'h5A, 1'b1, 0, 1'b0, "errscan");
    force_on = 1'b0;
    repeat (3) @(negedge clk);
    chk("err hold", err0, 1);
    chk("data hold", data0, 8'h5A);
    mux_in = 8'h81;
    run_op(1'b0, 1'b0, 3'd0, 8'h81, 1'b0, 0, 1'b0, "errclr");
    @(negedge clk);

    // Starts during busy and in DONE are dropped.
    mux_in = 8'hC3;
    run_op(1'b0, 1'b0, 3'd0, 8'hC3, 1'b0, 5, 1'b1, "ignscan");
    @(negedge clk);
    start = 1'b0;
    chk("ign idle busy", busy0, 0);
    chk("ign idle valid", valid0, 0);
    mux_in = 8'h96;
    run_op(1'b0, 1'b0, 3'd0, 8'h96, 1'b0, 0, 1'b0, "after");
    @(negedge clk);
    mux_in = 8'h08;
    run_op(1'b0, 1'b1, 3'd3, 8'h08, 1'b0, 1, 1'b0, "ignsingle");
    @(negedge clk);

    // Reset while sel=4.
    mux_in = 8'hA5;
    mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (sel0 != 3'd4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mid reached sel4", sel0, 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid sel", sel0, 0);
    chk("mid ce_n", ce_n0, 1);
    chk("mid busy", busy0, 0);
    chk("mid data", data0, 8'h00);
    chk("mid err", err0, 0);
    chk("mid valid", valid0, 0);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid0) n++;
    end
    chk("mid no valid", n, 0);

    // SETTLE_CYCLES=3 instance.
    mux_in = 8'h3C;
    run_op(1'b1, 1'b0, 3'd0, 8'h3C, 1'b0, 0, 1'b0, "s3scan");
    @(negedge clk);
    mux_in = 8'h40;
    run_op(1'b1, 1'b1, 3'd6, 8'h40, 1'b0, 0, 1'b0, "s3single");
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
